// File: rtl/pdp8lmtmux.sv
// pdp8lmtmux: DC02-style multi-terminal multiplexor with per-terminal ARM-filled keyboard FIFOs.
module pdp8lmtmux #(
    parameter int NTERM = 6,
    parameter int KBDEPTH = 4,
    parameter logic [5:0] DEVA = 6'o11
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        CSTEP,
    input  logic        armwrite,
    input  logic [3:0]  armraddr,
    input  logic [3:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic        iopstart,
    input  logic        iopstop,
    input  logic [11:0] ioopcode,
    input  logic [11:0] cputodev,
    output logic [11:0] devtocpu,
    output logic        AC_CLEAR,
    output logic        IO_SKIP,
    output logic        INT_RQST
);
    localparam int AW = $clog2(KBDEPTH);
    localparam logic [3:0] FULL = 4'(KBDEPTH);

    logic enable, intenab;
    logic [11:0] mton;
    logic [11:0] mem [12][KBDEPTH];
    logic [AW-1:0] rptr [12];
    logic [AW-1:0] wptr [12];
    logic [3:0] count [12];
    logic [11:0] prchar [12];
    logic [11:0] head [12];
    logic [11:0] ovf, prflag, prfull, sel, kbflag;
    logic [11:0] wr, push, flush, pop, push_ok;
    logic [11:0] kb_or, pf_bits, kf_bits, next_dtc;
    logic [2:0] fn;
    logic iot, dev_d, dev_e, mkcc, mkrs, mtcf, mtls, hit, next_skip;

    assign fn = ioopcode[2:0];
    assign iot = CSTEP & iopstart & enable & (ioopcode[11:9] == 3'o6);
    assign dev_d = iot & (ioopcode[8:3] == DEVA);
    assign dev_e = iot & (ioopcode[8:3] == DEVA + 6'd1);
    assign mkcc = dev_d & (fn == 3'd2 | fn == 3'd6);
    assign mkrs = dev_d & (fn == 3'd4 | fn == 3'd6);
    assign mtcf = dev_e & (fn == 3'd2);
    assign mtls = dev_e & (fn == 3'd6);
    assign hit = (dev_d & fn != 3'd0) | (dev_e & (fn == 3'd1 | fn == 3'd2 | fn == 3'd3 | fn == 3'd5 | fn == 3'd6));
    assign INT_RQST = intenab & |(sel & (kbflag | prflag));
    assign next_dtc = (mkrs ? kb_or : 12'd0) | (dev_d & fn == 3'd3 ? pf_bits : 12'd0)
                    | (dev_e & fn == 3'd3 ? kf_bits : 12'd0);
    assign next_skip = (dev_d & fn == 3'd1 & |(sel & kbflag)) | (dev_e & fn == 3'd1 & |(sel & prflag))
                     | (dev_e & fn == 3'd5 & INT_RQST);

    always_comb begin
        kb_or = '0;
        pf_bits = '0;
        kf_bits = '0;
        for (int n = 0; n < 12; n++) begin
            sel[n] = mton[11-n] && n < NTERM;
            kbflag[n] = count[n] != 4'd0;
            head[n] = kbflag[n] ? mem[n][rptr[n]] : 12'd0;
            kb_or = kb_or | (sel[n] ? head[n] : 12'd0);
            pf_bits[11-n] = prflag[n];
            kf_bits[11-n] = kbflag[n];
            wr[n] = armwrite && armwaddr == 4'(n + 2) && n < NTERM;
            push[n] = wr[n] & armwdata[24];
            flush[n] = wr[n] & armwdata[28];
            pop[n] = mkcc & sel[n] & kbflag[n];
            // a pop in the same cycle frees the slot a push into a full FIFO needs
            push_ok[n] = push[n] & (flush[n] | count[n] != FULL | pop[n]);
        end
    end

    always_comb begin
        armrdata = armraddr == 4'd0 ? 32'h44433001 :
                   armraddr == 4'd1 ? {enable, intenab, 2'b0, mton, 16'b0} : 32'd0;
        for (int n = 0; n < 12; n++)
            if (armraddr == 4'(n + 2) && n < NTERM)
                armrdata = {kbflag[n], prflag[n], prfull[n], ovf[n], count[n], prchar[n], head[n]};
    end

    always_ff @(posedge CLOCK) begin
        for (int n = 0; n < 12; n++) begin
            if (push_ok[n]) mem[n][flush[n] ? {AW{1'b0}} : wptr[n]] <= armwdata[11:0];
            if (wr[n] && armwdata[25]) prchar[n] <= armwdata[23:12];
            if (mtls && sel[n]) prchar[n] <= cputodev;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            enable <= 1'b1;
            intenab <= 1'b0;
            mton <= '0;
            ovf <= '0;
            prflag <= '0;
            prfull <= '0;
            devtocpu <= '0;
            AC_CLEAR <= 1'b0;
            IO_SKIP <= 1'b0;
            for (int n = 0; n < 12; n++) begin
                rptr[n] <= '0;
                wptr[n] <= '0;
                count[n] <= '0;
            end
        end else begin
            if (armwrite && armwaddr == 4'd1) enable <= armwdata[31];
            if (dev_d && fn == 3'd5) intenab <= cputodev[0];
            if (dev_d && fn == 3'd7) mton <= cputodev;
            if (hit) begin
                devtocpu <= next_dtc;
                AC_CLEAR <= mkcc;
                IO_SKIP <= next_skip;
            end else if (CSTEP && iopstop && !iopstart) begin
                devtocpu <= '0;
                AC_CLEAR <= 1'b0;
                IO_SKIP <= 1'b0;
            end
            for (int n = 0; n < 12; n++) begin
                if (flush[n]) begin
                    rptr[n] <= '0;
                    wptr[n] <= AW'(push[n]);
                    count[n] <= 4'(push[n]);
                    ovf[n] <= 1'b0;
                end else begin
                    rptr[n] <= rptr[n] + AW'(pop[n]);
                    wptr[n] <= wptr[n] + AW'(push_ok[n]);
                    count[n] <= count[n] + 4'(push_ok[n]) - 4'(pop[n]);
                    if (push[n] && !push_ok[n]) ovf[n] <= 1'b1;
                end
                if (wr[n] && armwdata[26]) prfull[n] <= armwdata[29];
                if (wr[n] && armwdata[27]) prflag[n] <= armwdata[30];
                // IOP updates come last so they override a same-cycle ARM write
                if ((mtcf || mtls) && sel[n]) prflag[n] <= 1'b0;
                if (mtls && sel[n]) prfull[n] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pdp8lmtmux.sv
// tb_pdp8lmtmux: directed and randomized checks of pdp8lmtmux against a queue-based terminal model.
module tb_pdp8lmtmux;
    localparam int NTERM = 6;
    localparam int KBDEPTH = 4;
    localparam logic [5:0] DEVA = 6'o11;

    logic CLOCK, RESET, CSTEP, armwrite, iopstart, iopstop;
    logic [3:0] armraddr, armwaddr;
    logic [31:0] armwdata, armrdata;
    logic [11:0] ioopcode, cputodev, devtocpu;
    logic AC_CLEAR, IO_SKIP, INT_RQST;

    pdp8lmtmux #(.NTERM(NTERM), .KBDEPTH(KBDEPTH), .DEVA(DEVA)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .CSTEP(CSTEP), .armwrite(armwrite),
        .armraddr(armraddr), .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata),
        .iopstart(iopstart), .iopstop(iopstop), .ioopcode(ioopcode), .cputodev(cputodev),
        .devtocpu(devtocpu), .AC_CLEAR(AC_CLEAR), .IO_SKIP(IO_SKIP), .INT_RQST(INT_RQST)
    );

    initial CLOCK = 1'b0;
    always #50 CLOCK = ~CLOCK;

    int tests = 0;
    int fails = 0;
    bit regs_ok = 0;

    bit m_en, m_ie, m_clr, m_skip;
    logic [11:0] m_mton, m_dtc;
    logic [11:0] mq [12][$];
    bit movf [12];
    bit mprf [12];
    bit mpfull [12];
    logic [11:0] mpch [12];

    logic [11:0] o_dtc;
    logic o_clr, o_skip;
    logic [31:0] v;

    logic [11:0] ops [13] = '{12'o6111, 12'o6112, 12'o6113, 12'o6114, 12'o6115, 12'o6116, 12'o6117,
                              12'o6121, 12'o6122, 12'o6123, 12'o6125, 12'o6126, 12'o6124};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit msel(int n);
        return n < NTERM && m_mton[11-n];
    endfunction

    function automatic bit mint();
        bit r = 0;
        for (int n = 0; n < NTERM; n++)
            if (msel(n) && (mq[n].size() != 0 || mprf[n])) r = 1;
        return m_ie & r;
    endfunction

    function automatic logic [31:0] mreg(int r);
        int n, sz;
        if (r == 0) return 32'h44433001;
        if (r == 1) return {m_en, m_ie, 2'b0, m_mton, 16'b0};
        if (r < 2 || r >= 2 + NTERM) return 32'd0;
        n = r - 2;
        sz = mq[n].size();
        return {sz != 0, mprf[n], mpfull[n], movf[n], 4'(sz), mpch[n], sz != 0 ? mq[n][0] : 12'd0};
    endfunction

    task automatic model_reset();
        m_en = 1; m_ie = 0; m_mton = 0; m_dtc = 0; m_clr = 0; m_skip = 0;
        for (int n = 0; n < 12; n++) begin
            mq[n].delete();
            movf[n] = 0; mprf[n] = 0; mpfull[n] = 0;
        end
    endtask

    task automatic model_step(input bit aw, input logic [3:0] wa, input logic [31:0] wd,
                              input bit io, input logic [11:0] op, input logic [11:0] ac);
        logic [2:0] f = op[2:0];
        bit isd = io && m_en && op[11:9] == 3'o6 && op[8:3] == DEVA;
        bit ise = io && m_en && op[11:9] == 3'o6 && op[8:3] == DEVA + 6'd1;
        bit rec = (isd && f != 0) || (ise && f inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6});
        bit clr = isd && (f == 2 || f == 6);
        bit skip = 0;
        logic [11:0] dtc = 0;
        for (int n = 0; n < NTERM; n++) begin
            if (isd && (f == 4 || f == 6) && msel(n) && mq[n].size() != 0) dtc |= mq[n][0];
            if (isd && f == 3) dtc[11-n] = mprf[n];
            if (ise && f == 3) dtc[11-n] = mq[n].size() != 0;
            if (isd && f == 1 && msel(n) && mq[n].size() != 0) skip = 1;
            if (ise && f == 1 && msel(n) && mprf[n]) skip = 1;
        end
        if (ise && f == 5 && mint()) skip = 1;
        if (rec) begin m_dtc = dtc; m_clr = clr; m_skip = skip; end
        for (int n = 0; n < NTERM; n++) begin
            bit w = aw && wa == 4'(n + 2);
            if (w && wd[28]) begin mq[n].delete(); movf[n] = 0; end
            else if (clr && msel(n) && mq[n].size() != 0) void'(mq[n].pop_front());
            if (w && wd[24]) begin
                if (mq[n].size() < KBDEPTH) mq[n].push_back(wd[11:0]);
                else movf[n] = 1;
            end
            if (w && wd[25]) mpch[n] = wd[23:12];
            if (w && wd[26]) mpfull[n] = wd[29];
            if (w && wd[27]) mprf[n] = wd[30];
            if (ise && (f == 2 || f == 6) && msel(n)) mprf[n] = 0;
            if (ise && f == 6 && msel(n)) begin mpfull[n] = 1; mpch[n] = ac; end
        end
        if (aw && wa == 4'd1) m_en = wd[31];
        if (isd && f == 5) m_ie = ac[0];
        if (isd && f == 7) m_mton = ac;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dtc"}, devtocpu, m_dtc);
        chk({tag, ".clr"}, AC_CLEAR, m_clr);
        chk({tag, ".skip"}, IO_SKIP, m_skip);
        chk({tag, ".int"}, INT_RQST, mint());
        if (regs_ok)
            for (int r = 0; r < 16; r++) begin
                armraddr = 4'(r);
                #1 chk($sformatf("%s.reg%0d", tag, r), armrdata, mreg(r));
            end
    endtask

    task automatic cyc(input bit aw, input logic [3:0] wa, input logic [31:0] wd,
                       input bit io, input logic [11:0] op, input logic [11:0] ac);
        armwrite = aw; armwaddr = wa; armwdata = wd;
        CSTEP = io; iopstart = io; ioopcode = op; cputodev = ac;
        model_step(aw, wa, wd, io, op, ac);
        @(posedge CLOCK); #1;
        armwrite = 0; CSTEP = 0; iopstart = 0;
        o_dtc = devtocpu; o_clr = AC_CLEAR; o_skip = IO_SKIP;
        check_all("start");
        if (io) begin
            CSTEP = 1; iopstop = 1;
            m_dtc = 0; m_clr = 0; m_skip = 0;
            @(posedge CLOCK); #1;
            CSTEP = 0; iopstop = 0;
            check_all("stop");
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        armraddr = a;
        #1 d = armrdata;
    endtask

    function automatic logic [31:0] pushw(logic [11:0] c);
        return 32'h0100_0000 | {20'd0, c};
    endfunction

    initial begin
        RESET = 1; CSTEP = 0; armwrite = 0; armraddr = 0; armwaddr = 0; armwdata = 0;
        iopstart = 0; iopstop = 0; ioopcode = 0; cputodev = 0;
        model_reset();
        repeat (2) @(posedge CLOCK);
        #1 RESET = 0;
        rd(4'd0, v); chk("reset.reg0", v, 32'h44433001);
        rd(4'd1, v); chk("reset.reg1", v, 32'h80000000);
        chk("reset.dtc", devtocpu, 12'd0);
        chk("reset.clr", AC_CLEAR, 1'b0);
        chk("reset.skip", IO_SKIP, 1'b0);
        chk("reset.int", INT_RQST, 1'b0);
        for (int n = 0; n < 12; n++) cyc(1, 4'(n + 2), 32'h0200_0000, 0, 0, 0);
        for (int n = 0; n < NTERM; n++) mpch[n] = 0;
        regs_ok = 1;
        cyc(0, 0, 0, 0, 0, 0);

        cyc(0, 0, 0, 1, 12'o6117, 12'o4000);
        cyc(1, 2, pushw(12'o0301), 0, 0, 0);
        cyc(1, 2, pushw(12'o0302), 0, 0, 0);
        cyc(1, 2, pushw(12'o0303), 0, 0, 0);
        cyc(0, 0, 0, 1, 12'o6111, 0); chk("mksf.skip", o_skip, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 12'o6116, 0);
            chk($sformatf("mkrb%0d.dtc", i), o_dtc, 12'o0301 + 12'(i));
            chk($sformatf("mkrb%0d.clr", i), o_clr, 1'b1);
        end
        rd(4'd2, v); chk("mkrb.count", v[27:24], 4'd0);
        cyc(0, 0, 0, 1, 12'o6111, 0); chk("mksf.noskip", o_skip, 1'b0);

        for (int i = 0; i < 5; i++) cyc(1, 2, pushw(12'o0401 + 12'(i)), 0, 0, 0);
        rd(4'd2, v);
        chk("ovf.count", v[27:24], 4'd4);
        chk("ovf.bit", v[28], 1'b1);
        chk("ovf.head", v[11:0], 12'o0401);
        cyc(1, 2, 32'h1000_0000, 0, 0, 0);
        rd(4'd2, v); chk("flush.word", v[31:24], 8'h00);

        cyc(0, 0, 0, 1, 12'o6117, 12'o6000);
        cyc(1, 2, pushw(12'o0001), 0, 0, 0);
        cyc(1, 3, pushw(12'o0100), 0, 0, 0);
        cyc(0, 0, 0, 1, 12'o6114, 0); chk("mkrs.dtc", o_dtc, 12'o0101);
        cyc(0, 0, 0, 1, 12'o6116, 0); chk("mkrb2.dtc", o_dtc, 12'o0101);
        rd(4'd2, v); chk("mkrb2.c0", v[27:24], 4'd0);
        rd(4'd3, v); chk("mkrb2.c1", v[27:24], 4'd0);

        cyc(0, 0, 0, 1, 12'o6115, 12'o0001);
        cyc(0, 0, 0, 1, 12'o6117, 12'o2000);
        cyc(1, 3, 32'h4800_0000, 0, 0, 0);
        chk("prflag.int", INT_RQST, 1'b1);
        cyc(0, 0, 0, 1, 12'o6125, 0); chk("mins.skip", o_skip, 1'b1);
        cyc(0, 0, 0, 1, 12'o6126, 12'o0215);
        rd(4'd3, v);
        chk("mtls.prflag", v[30], 1'b0);
        chk("mtls.prfull", v[29], 1'b1);
        chk("mtls.prchar", v[23:12], 12'o0215);
        chk("mtls.int", INT_RQST, 1'b0);

        for (int i = 0; i < 4; i++) cyc(1, 3, pushw(12'o0601 + 12'(i)), 0, 0, 0);
        cyc(1, 3, pushw(12'o0777), 1, 12'o6116, 0);
        chk("same.dtc", o_dtc, 12'o0601);
        rd(4'd3, v);
        chk("same.count", v[27:24], 4'd4);
        chk("same.ovf", v[28], 1'b0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 12'o6116, 0);
        chk("same.last", o_dtc, 12'o0777);

        cyc(1, 3, pushw(12'o0055), 0, 0, 0);
        cyc(1, 1, 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 1, 12'o6116, 0); chk("disabled.dtc", o_dtc, 12'o0000);
        cyc(1, 1, 32'h8000_0000, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] wa = 4'($urandom_range(0, 15));
            logic [31:0] wd = $urandom;
            logic [11:0] op = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 12)] : 12'($urandom);
            if (wa == 4'd1) wd[31] = $urandom_range(0, 7) != 0;
            if ($urandom_range(0, 3) != 0) wd[28] = 1'b0;
            cyc(1'($urandom_range(0, 1)), wa, wd, 1'($urandom_range(0, 1)), op, 12'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
